phase_sequencer: RTL and testbench

//  Parametrised successor to the fixed phase generator. Drives NUM_PHASES one-hot

---
 rtl/phase_sequencer.sv | 109 ++++++++++
 tb/tb_phase_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/phase_sequencer.sv
// One-hot instruction phase generator for the CPU datapath with run/halt toggle,
// decoder halt, single-step and memory stall; halts only on instruction boundaries.
`timescale 1ns/1ps

module phase_sequencer #(
  parameter int NUM_PHASES = 3,
  parameter bit RESET_RUN  = 1'b1,
  parameter int IDX_W      = $clog2(NUM_PHASES)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  exec,
  input  logic                  halt_req,
  input  logic                  step,
  input  logic                  stall,
  output logic [NUM_PHASES-1:0] phase,
  output logic [IDX_W-1:0]      phase_idx,
  output logic                  running,
  output logic                  instr_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_STEP
  } state_e;

  localparam state_e RESET_STATE = RESET_RUN ? S_RUN : S_IDLE;

  state_e                state_q, state_d;
  logic [NUM_PHASES-1:0] phase_q, phase_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  exec_q, exec_d;

  logic exec_edge;
  logic boundary;
  logic keep_running;

  assign exec_edge = exec & ~exec_q;
  assign boundary  = (state_q != S_IDLE) & phase_q[NUM_PHASES-1] & ~stall;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    idx_d        = idx_q;
    exec_d       = exec;
    keep_running = 1'b0;

    // Requests are captured into state even while stalled; they act at the boundary.
    unique case (state_q)
      S_IDLE: begin
        if (exec_edge)      state_d = S_RUN;
        else if (step)      state_d = S_STEP;
      end
      S_RUN: begin
        if (halt_req || exec_edge) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (!halt_req && exec_edge) state_d = S_RUN;
      end
      S_STEP: ;
      default: state_d = S_IDLE;
    endcase

    if (boundary) begin
      keep_running = (state_q == S_RUN) && !halt_req && !exec_edge;
      idx_d        = '0;
      if (keep_running) begin
        state_d = S_RUN;
        phase_d = NUM_PHASES'(1);
      end else begin
        state_d = S_IDLE;
        phase_d = '0;
      end
    end else if (state_d != S_IDLE && !stall) begin
      // Leaving IDLE loads phase[0] at once so running and phase rise together.
      if (phase_q == '0) begin
        phase_d = NUM_PHASES'(1);
        idx_d   = '0;
      end else begin
        phase_d = phase_q << 1;
        idx_d   = idx_q + IDX_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RESET_STATE;
      phase_q <= '0;
      idx_q   <= '0;
      exec_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
      exec_q  <= exec_d;
    end
  end

  assign phase      = phase_q;
  assign phase_idx  = idx_q;
  assign running    = (state_q != S_IDLE);
  assign instr_done = phase_q[NUM_PHASES-1] & ~stall;

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: directed vector table on a 3-phase instance, a reset
// sequence on a 5-phase idle-after-reset instance, and random stimulus vs a model.
`timescale 1ns/1ps

module tb_phase_sequencer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic rst3, rst5, exec, halt_req, step, stall;
  logic [2:0] ph3;
  logic [1:0] idx3;
  logic       run3, done3;
  logic [4:0] ph5;
  logic [2:0] idx5;
  logic       run5, done5;

  phase_sequencer #(.NUM_PHASES(3), .RESET_RUN(1'b1)) dut3 (
    .clock(clock), .reset(rst3), .exec(exec), .halt_req(halt_req), .step(step),
    .stall(stall), .phase(ph3), .phase_idx(idx3), .running(run3), .instr_done(done3)
  );

  phase_sequencer #(.NUM_PHASES(5), .RESET_RUN(1'b0)) dut5 (
    .clock(clock), .reset(rst5), .exec(exec), .halt_req(halt_req), .step(step),
    .stall(stall), .phase(ph5), .phase_idx(idx5), .running(run5), .instr_done(done5)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference model: position within the instruction (-1 when none) plus request flags.
  typedef struct {
    int pos;
    bit active;
    bit stop_pending;
    bit one_shot;
    bit prev_exec;
  } mdl_t;

  function automatic mdl_t mdl_next(mdl_t m, int n, bit rr, bit rst, bit ex, bit hr,
                                    bit st, bit sl);
    mdl_t r;
    bit ed;
    r  = m;
    ed = ex && !m.prev_exec;
    if (rst) begin
      r.pos = -1; r.active = rr; r.stop_pending = 0; r.one_shot = 0; r.prev_exec = 1;
      return r;
    end
    r.prev_exec = ex;
    if (!m.active) begin
      if (ed || st) begin
        r.active = 1; r.one_shot = !ed; r.stop_pending = 0;
        if (!sl) r.pos = 0;
      end
    end else if (m.pos == n - 1 && !sl) begin
      if (m.one_shot || m.stop_pending || hr || ed) begin
        r.active = 0; r.pos = -1; r.one_shot = 0; r.stop_pending = 0;
      end else begin
        r.pos = 0;
      end
    end else begin
      if (!m.one_shot) begin
        if (hr)      r.stop_pending = 1;
        else if (ed) r.stop_pending = !m.stop_pending;
      end
      if (!sl) r.pos = m.pos + 1;
    end
    return r;
  endfunction

  task automatic check_model(input string tag, input mdl_t m, input int n,
                             input logic [31:0] ph, input logic [31:0] idx,
                             input logic run, input logic done);
    check({tag, ".phase"}, ph, (m.pos < 0) ? 0 : (32'd1 << m.pos));
    check({tag, ".idx"}, idx, (m.pos < 0) ? 0 : m.pos);
    check({tag, ".running"}, {31'd0, run}, {31'd0, m.active});
    check({tag, ".done"}, {31'd0, done}, {31'd0, (m.pos == n - 1) && !stall});
  endtask

  typedef struct {
    bit rst, ex, hr, st, sl;
    logic [2:0] ph;
    int idx;
    bit run, done;
  } vec_t;

  function automatic vec_t mk(bit rst, bit ex, bit hr, bit st, bit sl,
                              logic [2:0] ph, int idx, bit run, bit done);
    vec_t v;
    v.rst = rst; v.ex = ex; v.hr = hr; v.st = st; v.sl = sl;
    v.ph = ph; v.idx = idx; v.run = run; v.done = done;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    mdl_t m3, m5;

    // rst ex hr st sl | phase idx running instr_done (after the edge)
    tbl.push_back(mk(1,0,0,0,0, 3'b000,0,1,0));  // reset -> RUN, no phase yet
    tbl.push_back(mk(0,0,0,0,0, 3'b001,0,1,0));
    tbl.push_back(mk(0,0,0,0,0, 3'b010,1,1,0));
    tbl.push_back(mk(0,0,0,0,0, 3'b100,2,1,1));
    tbl.push_back(mk(0,0,0,0,0, 3'b001,0,1,0));
    tbl.push_back(mk(0,0,0,0,0, 3'b010,1,1,0));
    tbl.push_back(mk(0,0,1,0,0, 3'b100,2,1,1));  // halt_req on 010
    tbl.push_back(mk(0,0,0,0,0, 3'b000,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 3'b000,0,0,0));
    tbl.push_back(mk(0,1,0,0,0, 3'b001,0,1,0));  // exec edge, held 10 cycles
    tbl.push_back(mk(0,1,0,0,0, 3'b010,1,1,0));
    tbl.push_back(mk(0,1,0,0,0, 3'b100,2,1,1));
    tbl.push_back(mk(0,1,0,0,0, 3'b001,0,1,0));
    tbl.push_back(mk(0,1,0,0,0, 3'b010,1,1,0));
    tbl.push_back(mk(0,1,0,0,0, 3'b100,2,1,1));
    tbl.push_back(mk(0,1,0,0,0, 3'b001,0,1,0));
    tbl.push_back(mk(0,1,0,0,0, 3'b010,1,1,0));
    tbl.push_back(mk(0,1,0,0,0, 3'b100,2,1,1));
    tbl.push_back(mk(0,1,0,0,0, 3'b001,0,1,0));
    tbl.push_back(mk(0,0,0,0,0, 3'b010,1,1,0));
    tbl.push_back(mk(0,1,0,0,0, 3'b100,2,1,1));  // second edge -> drain
    tbl.push_back(mk(0,1,0,0,0, 3'b000,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 3'b000,0,0,0));
    tbl.push_back(mk(0,0,0,1,0, 3'b001,0,1,0));  // single step
    tbl.push_back(mk(0,0,0,1,0, 3'b010,1,1,0));  // step again: ignored
    tbl.push_back(mk(0,0,0,0,0, 3'b100,2,1,1));
    tbl.push_back(mk(0,0,0,0,0, 3'b000,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 3'b000,0,0,0));
    tbl.push_back(mk(0,1,0,0,0, 3'b001,0,1,0));
    tbl.push_back(mk(0,1,0,0,0, 3'b010,1,1,0));
    tbl.push_back(mk(0,1,0,0,1, 3'b010,1,1,0));  // stall 4 cycles on 010
    tbl.push_back(mk(0,1,1,0,1, 3'b010,1,1,0));
    tbl.push_back(mk(0,1,0,0,1, 3'b010,1,1,0));
    tbl.push_back(mk(0,1,0,0,1, 3'b010,1,1,0));
    tbl.push_back(mk(0,1,0,0,0, 3'b100,2,1,1));
    tbl.push_back(mk(0,1,0,0,0, 3'b000,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 3'b000,0,0,0));
    tbl.push_back(mk(0,1,0,0,0, 3'b001,0,1,0));
    tbl.push_back(mk(0,1,0,0,0, 3'b010,1,1,0));
    tbl.push_back(mk(0,1,0,0,0, 3'b100,2,1,1));
    tbl.push_back(mk(0,1,0,0,1, 3'b100,2,1,0));  // stall on the last phase
    tbl.push_back(mk(0,1,0,0,0, 3'b001,0,1,0));
    tbl.push_back(mk(0,0,0,0,0, 3'b010,1,1,0));
    tbl.push_back(mk(0,1,0,0,1, 3'b010,1,1,0));  // edge -> drain while stalled
    tbl.push_back(mk(0,0,0,0,1, 3'b010,1,1,0));
    tbl.push_back(mk(0,1,0,0,1, 3'b010,1,1,0));  // second edge cancels
    tbl.push_back(mk(0,1,0,0,0, 3'b100,2,1,1));
    tbl.push_back(mk(0,1,0,0,0, 3'b001,0,1,0));
    tbl.push_back(mk(0,1,1,0,0, 3'b010,1,1,0));
    tbl.push_back(mk(0,1,0,0,0, 3'b100,2,1,1));
    tbl.push_back(mk(0,1,0,0,0, 3'b000,0,0,0));
    tbl.push_back(mk(0,1,1,0,0, 3'b000,0,0,0));  // halt_req in IDLE ignored
    tbl.push_back(mk(0,0,0,0,0, 3'b000,0,0,0));
    tbl.push_back(mk(0,1,0,0,0, 3'b001,0,1,0));
    tbl.push_back(mk(0,1,0,0,0, 3'b010,1,1,0));
    tbl.push_back(mk(0,1,0,0,0, 3'b100,2,1,1));
    tbl.push_back(mk(0,1,1,0,0, 3'b000,0,0,0));  // halt at boundary: straight to IDLE
    tbl.push_back(mk(0,1,0,0,0, 3'b000,0,0,0));

    rst3 = 1'b1; rst5 = 1'b1; exec = 1'b0; halt_req = 1'b0; step = 1'b0; stall = 1'b0;
    #1;

    for (int i = 0; i < tbl.size(); i++) begin
      rst3 = tbl[i].rst; exec = tbl[i].ex; halt_req = tbl[i].hr;
      step = tbl[i].st;  stall = tbl[i].sl;
      tick();
      check($sformatf("vec%0d.phase", i), {29'd0, ph3}, {29'd0, tbl[i].ph});
      check($sformatf("vec%0d.idx", i), {30'd0, idx3}, tbl[i].idx);
      check($sformatf("vec%0d.running", i), {31'd0, run3}, {31'd0, tbl[i].run});
      check($sformatf("vec%0d.done", i), {31'd0, done3}, {31'd0, tbl[i].done});
    end

    // 5-phase, idle after reset: reset mid-instruction, exec held through reset.
    halt_req = 1'b0; step = 1'b0; stall = 1'b0;
    rst5 = 1'b1; exec = 1'b0; tick();
    check("n5.reset.phase", {27'd0, ph5}, 32'd0);
    check("n5.reset.running", {31'd0, run5}, 32'd0);
    rst5 = 1'b0; tick();
    check("n5.idle.running", {31'd0, run5}, 32'd0);
    exec = 1'b1; tick();
    check("n5.start.phase", {27'd0, ph5}, 32'h01);
    tick();
    check("n5.p1.phase", {27'd0, ph5}, 32'h02);
    tick();
    check("n5.p2.phase", {27'd0, ph5}, 32'h04);
    check("n5.p2.idx", {29'd0, idx5}, 32'd2);
    rst5 = 1'b1; tick();
    check("n5.midreset.phase", {27'd0, ph5}, 32'd0);
    check("n5.midreset.running", {31'd0, run5}, 32'd0);
    rst5 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("n5.held%0d.phase", i), {27'd0, ph5}, 32'd0);
      check($sformatf("n5.held%0d.running", i), {31'd0, run5}, 32'd0);
    end

    // Random stimulus against the model, both instances.
    rst3 = 1'b1; rst5 = 1'b1; exec = 1'b0;
    m3 = mdl_next(m3, 3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    m5 = mdl_next(m5, 5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 1500; i++) begin
      rst3     = ($urandom_range(0, 199) == 0);
      rst5     = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 5) == 0) exec = ~exec;
      halt_req = ($urandom_range(0, 15) == 0);
      step     = ($urandom_range(0, 7) == 0);
      stall    = ($urandom_range(0, 3) == 0);
      m3 = mdl_next(m3, 3, 1'b1, rst3, exec, halt_req, step, stall);
      m5 = mdl_next(m5, 5, 1'b0, rst5, exec, halt_req, step, stall);
      tick();
      check_model($sformatf("rnd%0d.n3", i), m3, 3, {29'd0, ph3}, {30'd0, idx3}, run3, done3);
      check_model($sformatf("rnd%0d.n5", i), m5, 5, {27'd0, ph5}, {29'd0, idx5}, run5, done5);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
